// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: access-size codes and the
// posted-store entry record used by the store buffer.
package mem_pkg;

    localparam int DM_AW = 13;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [2:0] LBU = 3'b011;
    localparam logic [2:0] LB  = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LH  = 3'b110;
    localparam logic [2:0] LW  = 3'b111;

    typedef struct packed {
        logic [DM_AW-1:0] addr;
        logic [31:0]      data;
        logic [2:0]       sel;
    } st_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular store queue with a parallel word-address compare across
// all valid entries, used to hold back loads that would read stale data.
module store_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  st_entry_t        i_entry,
    input  logic             i_pop,
    input  logic [DM_AW-3:0] i_word,
    output st_entry_t        o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_match
);

    st_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            w_match;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An entry is live when its distance from head is below count.
    always_comb begin
        logic [PW-1:0] w_off;
        w_match = 1'b0;
        w_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_head;
            if (({1'b0, w_off} < r_count) &&
                (r_mem[i].addr[DM_AW-1:2] == i_word)) begin
                w_match = 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;
    assign o_match = w_match;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of dm: loads win the shared port, stores
// drain in idle cycles, and loads to a pending word wait for the drain.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = DM_AW,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [2:0]    st_sel,
    output logic          st_ready,
    output logic          st_misalign,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [2:0]    ld_sel,
    output logic          ld_stall,
    output logic          dm_wr,
    output logic [2:0]    dm_sel,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    output logic [CW-1:0] count,
    output logic          empty
);

    st_entry_t     w_entry;
    st_entry_t     w_head;
    logic [CW-1:0] w_count;
    logic          w_match;
    logic          w_full;
    logic          w_empty;
    logic          w_bad_align;
    logic          w_misalign;
    logic          w_push;
    logic          w_ld_grant;
    logic          w_pop;

    always_comb begin
        w_bad_align = 1'b0;
        case (st_sel)
            SB:      w_bad_align = 1'b0;
            SH:      w_bad_align = st_addr[0];
            default: w_bad_align = (st_addr[1:0] != 2'b00);
        endcase
    end

    assign w_misalign = st_valid && w_bad_align;
    assign w_full     = (w_count == CW'(DEPTH));
    assign w_empty    = (w_count == '0);
    assign w_push     = st_valid && !w_full && !w_misalign;

    assign w_entry.addr = st_addr;
    assign w_entry.data = st_data;
    assign w_entry.sel  = st_sel;

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_word  (ld_addr[AW-1:2]),
        .o_head  (w_head),
        .o_count (w_count),
        .o_match (w_match)
    );

    // A stalled load yields the port so the blocking store can drain.
    assign ld_stall   = ld_valid && (w_match || w_full);
    assign w_ld_grant = ld_valid && !ld_stall;
    assign w_pop      = !w_ld_grant && !w_empty;

    always_comb begin
        dm_wr   = 1'b0;
        dm_addr = ld_addr;
        dm_sel  = ld_sel;
        if (w_pop) begin
            dm_wr   = 1'b1;
            dm_addr = w_head.addr;
            dm_sel  = w_head.sel;
        end
    end

    assign dm_din      = w_empty ? 32'h0 : w_head.data;
    assign st_ready    = !w_full;
    assign st_misalign = w_misalign;
    assign count       = w_count;
    assign empty       = w_empty;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected dm writes are queued as
// stores are driven and checked in order whenever dm_wr is seen.
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic [12:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_sel;
    logic        st_ready;
    logic        st_misalign;
    logic        ld_valid;
    logic [12:0] ld_addr;
    logic [2:0]  ld_sel;
    logic        ld_stall;
    logic        dm_wr;
    logic [2:0]  dm_sel;
    logic [12:0] dm_addr;
    logic [31:0] dm_din;
    logic [2:0]  count;
    logic        empty;

    typedef struct {
        logic [12:0] a;
        logic [2:0]  s;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    bit   allow_overlap;

    store_buffer #(.DEPTH(4), .AW(13)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_sel      (st_sel),
        .st_ready    (st_ready),
        .st_misalign (st_misalign),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_sel      (ld_sel),
        .ld_stall    (ld_stall),
        .dm_wr       (dm_wr),
        .dm_sel      (dm_sel),
        .dm_addr     (dm_addr),
        .dm_din      (dm_din),
        .count       (count),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dm write monitor: every write must match the oldest expected store
    always @(negedge clk) begin
        if (dm_wr) begin
            total++;
            if (rst) begin
                bad++;
                $display("FAIL wr_in_reset: dm_wr=%0b required 0", dm_wr);
            end else if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_wr: addr=%h din=%h required no write",
                         dm_addr, dm_din);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (dm_addr !== e.a || dm_sel !== e.s || dm_din !== e.d) begin
                    bad++;
                    $display("FAIL wr_data: got a=%h s=%b d=%h required a=%h s=%b d=%h",
                             dm_addr, dm_sel, dm_din, e.a, e.s, e.d);
                end
            end
        end
        if (!allow_overlap && st_valid && ld_valid) begin
            bad++;
            $display("FAIL exclusive: st_valid=1 ld_valid=1 required not both");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        st_valid = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic drive_st(input logic [12:0] a, input logic [2:0] s,
                            input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_sel   = s;
        st_data  = d;
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (!(empty === 1'b1 && q.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        @(negedge clk);
        total++;
        if (empty !== 1'b1 || q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: empty=%b pending=%0d required empty=1 pending=0",
                     empty, q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: count=%0d empty=%b ready=%b required 0 1 1",
                     count, empty, st_ready);
        end
        total++;
        if (dm_wr !== 1'b0 || ld_stall !== 1'b0 || st_misalign !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs: wr=%b stall=%b mis=%b required 0 0 0",
                     dm_wr, ld_stall, st_misalign);
        end
        total++;
        if (dm_din !== 32'h0) begin
            bad++;
            $display("FAIL reset_din: din=%h required 0", dm_din);
        end
    endtask

    task automatic test_sb();
        tick();
        drive_st(13'h005, 3'b000, 32'h0000_00AB);
        q.push_back('{13'h005, 3'b000, 32'h0000_00AB});
        tick();
        idle();
        @(negedge clk);
        total++;
        if (dm_wr !== 1'b1 || dm_addr !== 13'h005 || dm_sel !== 3'b000) begin
            bad++;
            $display("FAIL sb_drain: wr=%b addr=%h sel=%b required 1 005 000",
                     dm_wr, dm_addr, dm_sel);
        end
        tick();
        @(negedge clk);
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL sb_empty: empty=%b required 1", empty);
        end
    endtask

    task automatic test_fill();
        allow_overlap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            drive_st(13'(4 * i), 3'b010, 32'hA0 + 32'(i));
            ld_valid = 1'b1;
            ld_addr  = 13'h100;
            ld_sel   = 3'b111;
            q.push_back('{13'(4 * i), 3'b010, 32'hA0 + 32'(i)});
            @(negedge clk);
            total++;
            if (ld_stall !== 1'b0 || dm_wr !== 1'b0 || dm_addr !== 13'h100) begin
                bad++;
                $display("FAIL fill_ld%0d: stall=%b wr=%b addr=%h required 0 0 100",
                         i, ld_stall, dm_wr, dm_addr);
            end
        end
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        total++;
        if (count !== 3'd4 || st_ready !== 1'b0 || ld_stall !== 1'b1) begin
            bad++;
            $display("FAIL full: count=%0d ready=%b stall=%b required 4 0 1",
                     count, st_ready, ld_stall);
        end
        tick();
        @(negedge clk);
        total++;
        if (count !== 3'd3 || ld_stall !== 1'b0 || dm_addr !== 13'h100) begin
            bad++;
            $display("FAIL unstall: count=%0d stall=%b addr=%h required 3 0 100",
                     count, ld_stall, dm_addr);
        end
        tick();
        idle();
        allow_overlap = 1'b0;
        wait_empty(20);
    endtask

    task automatic test_hazard();
        tick();
        drive_st(13'h010, 3'b010, 32'h1234_5678);
        q.push_back('{13'h010, 3'b010, 32'h1234_5678});
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 13'h012;
        ld_sel   = 3'b111;
        @(negedge clk);
        total++;
        if (ld_stall !== 1'b1 || dm_wr !== 1'b1) begin
            bad++;
            $display("FAIL hit_stall: stall=%b wr=%b required 1 1", ld_stall, dm_wr);
        end
        tick();
        @(negedge clk);
        total++;
        if (ld_stall !== 1'b0 || dm_wr !== 1'b0 || dm_addr !== 13'h012 ||
            dm_sel !== 3'b111) begin
            bad++;
            $display("FAIL hit_grant: stall=%b wr=%b addr=%h sel=%b required 0 0 012 111",
                     ld_stall, dm_wr, dm_addr, dm_sel);
        end
        tick();
        idle();
        wait_empty(10);
    endtask

    task automatic test_misalign();
        logic [12:0] ta [3] = '{13'h003, 13'h006, 13'h002};
        logic [2:0]  ts [3] = '{3'b001, 3'b010, 3'b001};
        logic        tm [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_st(ta[i], ts[i], 32'hC0DE_0000 + 32'(i));
            if (!tm[i]) q.push_back('{ta[i], ts[i], 32'hC0DE_0000 + 32'(i)});
            @(negedge clk);
            total++;
            if (st_misalign !== tm[i]) begin
                bad++;
                $display("FAIL misalign%0d: mis=%b required %b", i, st_misalign, tm[i]);
            end
            tick();
            idle();
            @(negedge clk);
            total++;
            if (count !== (tm[i] ? 3'd0 : 3'd1)) begin
                bad++;
                $display("FAIL mis_count%0d: count=%0d required %0d",
                         i, count, tm[i] ? 0 : 1);
            end
            wait_empty(10);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            tick();
            drive_st(13'h040 + 13'(4 * i), 3'b010, 32'h1000 + 32'(i));
            q.push_back('{13'h040 + 13'(4 * i), 3'b010, 32'h1000 + 32'(i)});
            if (i > 0) begin
                @(negedge clk);
                total++;
                if (count !== 3'd1) begin
                    bad++;
                    $display("FAIL steady%0d: count=%0d required 1", i, count);
                end
            end
        end
        tick();
        idle();
        wait_empty(10);
    endtask

    task automatic test_rst_mid();
        allow_overlap = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_st(13'h080 + 13'(4 * i), 3'b010, 32'hDEAD_0000 + 32'(i));
            ld_valid = 1'b1;
            ld_addr  = 13'h1F0;
            ld_sel   = 3'b111;
        end
        tick();
        idle();
        allow_overlap = 1'b0;
        total++;
        if (count !== 3'd3) begin
            bad++;
            $display("FAIL pre_rst: count=%0d required 3", count);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || dm_wr !== 1'b0 || dm_din !== 32'h0) begin
            bad++;
            $display("FAIL async_rst: count=%0d empty=%b wr=%b din=%h required 0 1 0 0",
                     count, empty, dm_wr, dm_din);
        end
        q.delete();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        total++;
        if (empty !== 1'b1 || st_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_rst: empty=%b ready=%b required 1 1", empty, st_ready);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        allow_overlap = 1'b0;
        rst = 1'b1;
        st_valid = 1'b0;
        st_addr = '0;
        st_data = '0;
        st_sel = '0;
        ld_valid = 1'b0;
        ld_addr = '0;
        ld_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_sb();
        test_fill();
        test_hazard();
        test_misalign();
        test_back_to_back();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
